mips: RTL and testbench

MIPS -- requirements
Module: mips

---
 rtl/mips_pkg.sv | 35 +++
 rtl/mips_alu.sv | 27 ++
 rtl/mips.sv | 215 +++++++++++++++++++++
 tb/tb_mips.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared opcode encodings, instruction field positions and small decode helpers
// for the five-stage MIPS-subset pipeline.
package mips_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU; the caller maps immediate/memory opcodes onto ADD/SUB/SLT.
module mips_alu
    import mips_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result
);

    logic [31:0] w_prod;
    assign w_prod = i_a * i_b;

    always_comb begin
        o_result = 32'd0;
        case (i_op)
            OP_ADD: o_result = i_a + i_b;
            OP_SUB: o_result = i_a - i_b;
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_SLT: o_result = {31'd0, $signed(i_a) < $signed(i_b)};
            OP_MUL: o_result = w_prod;
            default: o_result = 32'd0;
        endcase
    end

endmodule

// File: rtl/mips.sv
// Five-stage in-order MIPS-subset pipeline with a unified memory, interlocks
// instead of forwarding, branches resolved in EX, and HLT draining to WB.
module mips
    import mips_pkg::*;
#(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] out_result,
    output logic [31:0] out_PC,
    output logic        halted_out
);

    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [5:0] ADD   = OP_ADD;
    localparam logic [5:0] SUB   = OP_SUB;
    localparam logic [5:0] AND   = OP_AND;
    localparam logic [5:0] OR    = OP_OR;
    localparam logic [5:0] SLT   = OP_SLT;
    localparam logic [5:0] MUL   = OP_MUL;
    localparam logic [5:0] LW    = OP_LW;
    localparam logic [5:0] SW    = OP_SW;
    localparam logic [5:0] ADDI  = OP_ADDI;
    localparam logic [5:0] SUBI  = OP_SUBI;
    localparam logic [5:0] SLTI  = OP_SLTI;
    localparam logic [5:0] BNEQZ = OP_BNEQZ;
    localparam logic [5:0] BEQZ  = OP_BEQZ;
    localparam logic [5:0] HLT   = OP_HLT;

    logic [31:0] regs [0:31];
    logic [31:0] Mem  [0:MEM_DEPTH-1];
    logic [31:0] PC;
    logic        halted;
    logic        taken_branch;
    logic        stall;

    logic        r_fetch_stop;
    logic [31:0] r_out_result;

    logic        r_ifid_valid;
    logic [31:0] r_ifid_ir;
    logic [31:0] r_ifid_npc;

    logic        r_idex_valid;
    logic [5:0]  r_idex_op;
    logic [31:0] r_idex_a;
    logic [31:0] r_idex_b;
    logic [31:0] r_idex_imm;
    logic [4:0]  r_idex_dest;
    logic [31:0] r_idex_npc;

    logic        r_exmem_valid;
    logic [5:0]  r_exmem_op;
    logic [31:0] r_exmem_alu;
    logic [31:0] r_exmem_b;
    logic [4:0]  r_exmem_dest;

    logic        r_memwb_valid;
    logic [5:0]  r_memwb_op;
    logic [31:0] r_memwb_alu;
    logic [31:0] r_memwb_lmd;
    logic [4:0]  r_memwb_dest;

    // ---------------- ID decode ----------------
    logic [5:0]  w_id_op;
    logic [4:0]  w_id_rs, w_id_rt, w_id_rd, w_id_dest;
    logic [31:0] w_id_imm, w_id_a, w_id_b;
    logic        w_id_rtype, w_id_wrt, w_id_use_rs, w_id_use_rt, w_id_hlt;
    logic        w_hz_rs, w_hz_rt;

    assign w_id_op  = r_ifid_ir[OP_HI:OP_LO];
    assign w_id_rs  = r_ifid_ir[RS_HI:RS_LO];
    assign w_id_rt  = r_ifid_ir[RT_HI:RT_LO];
    assign w_id_rd  = r_ifid_ir[RD_HI:RD_LO];
    assign w_id_imm = sext16(r_ifid_ir[IMM_HI:IMM_LO]);

    assign w_id_rtype  = w_id_op inside {ADD, SUB, AND, OR, SLT, MUL};
    assign w_id_wrt    = w_id_op inside {LW, ADDI, SUBI, SLTI};
    assign w_id_use_rs = w_id_rtype || w_id_wrt || (w_id_op inside {SW, BEQZ, BNEQZ});
    assign w_id_use_rt = w_id_rtype || (w_id_op == SW);
    assign w_id_dest   = w_id_rtype ? w_id_rd : (w_id_wrt ? w_id_rt : 5'd0);
    assign w_id_hlt    = r_ifid_valid && (w_id_op == HLT);

    // ---------------- WB (write-through into ID reads) ----------------
    logic        w_wb_we;
    logic [31:0] w_wb_val;
    assign w_wb_we  = r_memwb_valid && (r_memwb_dest != 5'd0);
    assign w_wb_val = (r_memwb_op == LW) ? r_memwb_lmd : r_memwb_alu;

    assign w_id_a = (w_id_rs == 5'd0) ? 32'd0 :
                    (w_wb_we && r_memwb_dest == w_id_rs) ? w_wb_val : regs[w_id_rs];
    assign w_id_b = (w_id_rt == 5'd0) ? 32'd0 :
                    (w_wb_we && r_memwb_dest == w_id_rt) ? w_wb_val : regs[w_id_rt];

    // Destinations of non-writers are 0, so a zero match never interlocks.
    assign w_hz_rs = (w_id_rs != 5'd0) &&
                     ((r_idex_valid  && r_idex_dest  == w_id_rs) ||
                      (r_exmem_valid && r_exmem_dest == w_id_rs));
    assign w_hz_rt = (w_id_rt != 5'd0) &&
                     ((r_idex_valid  && r_idex_dest  == w_id_rt) ||
                      (r_exmem_valid && r_exmem_dest == w_id_rt));
    assign stall   = r_ifid_valid && ((w_id_use_rs && w_hz_rs) || (w_id_use_rt && w_hz_rt));

    // ---------------- EX ----------------
    logic [5:0]  w_alu_op;
    logic [31:0] w_alu_b, w_alu_out, w_target;
    logic        w_ex_rtype;

    assign w_ex_rtype = r_idex_op inside {ADD, SUB, AND, OR, SLT, MUL};
    assign w_alu_b    = w_ex_rtype ? r_idex_b : r_idex_imm;
    assign w_target   = r_idex_npc + r_idex_imm;

    always_comb begin
        w_alu_op = r_idex_op;
        case (r_idex_op)
            LW, SW, ADDI: w_alu_op = ADD;
            SUBI:         w_alu_op = SUB;
            SLTI:         w_alu_op = SLT;
            default:      w_alu_op = r_idex_op;
        endcase
    end

    mips_alu u_alu (
        .i_op     (w_alu_op),
        .i_a      (r_idex_a),
        .i_b      (w_alu_b),
        .o_result (w_alu_out)
    );

    assign taken_branch = r_idex_valid &&
                          (((r_idex_op == BEQZ)  && (r_idex_a == 32'd0)) ||
                           ((r_idex_op == BNEQZ) && (r_idex_a != 32'd0)));

    // ---------------- Memory and register file arrays ----------------
    logic w_run, w_mem_we, w_if_fetch;
    assign w_run      = !rst && !halted;
    assign w_mem_we   = w_run && r_exmem_valid && (r_exmem_op == SW);
    assign w_if_fetch = w_run && !taken_branch && !stall && !w_id_hlt && !r_fetch_stop;

    always_ff @(posedge clk) begin
        if (w_mem_we)
            Mem[r_exmem_alu[AW-1:0]] <= r_exmem_b;
        if (w_if_fetch)
            r_ifid_ir <= Mem[PC[AW-1:0]];
        if (w_run)
            r_memwb_lmd <= Mem[r_exmem_alu[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (w_run && w_wb_we)
            regs[r_memwb_dest] <= w_wb_val;
    end

    // ---------------- Pipeline control ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            PC            <= 32'd0;
            halted        <= 1'b0;
            r_fetch_stop  <= 1'b0;
            r_out_result  <= 32'd0;
            r_ifid_valid  <= 1'b0;
            r_idex_valid  <= 1'b0;
            r_exmem_valid <= 1'b0;
            r_memwb_valid <= 1'b0;
        end else if (!halted) begin
            if (w_wb_we)
                r_out_result <= w_wb_val;
            if (r_memwb_valid && r_memwb_op == HLT)
                halted <= 1'b1;

            r_memwb_valid <= r_exmem_valid;
            r_memwb_op    <= r_exmem_op;
            r_memwb_alu   <= r_exmem_alu;
            r_memwb_dest  <= r_exmem_dest;

            r_exmem_valid <= r_idex_valid;
            r_exmem_op    <= r_idex_op;
            r_exmem_alu   <= w_alu_out;
            r_exmem_b     <= r_idex_b;
            r_exmem_dest  <= r_idex_dest;

            if (taken_branch) begin
                PC           <= w_target;
                r_ifid_valid <= 1'b0;
                r_idex_valid <= 1'b0;
            end else if (stall) begin
                r_idex_valid <= 1'b0;
            end else begin
                r_idex_valid <= r_ifid_valid;
                r_idex_op    <= w_id_op;
                r_idex_a     <= w_id_a;
                r_idex_b     <= w_id_b;
                r_idex_imm   <= w_id_imm;
                r_idex_dest  <= w_id_dest;
                r_idex_npc   <= r_ifid_npc;
                // Once HLT leaves ID nothing younger may enter the pipe.
                if (w_id_hlt || r_fetch_stop) begin
                    r_fetch_stop <= 1'b1;
                    r_ifid_valid <= 1'b0;
                end else begin
                    r_ifid_valid <= 1'b1;
                    r_ifid_npc   <= PC + 32'd1;
                    PC           <= PC + 32'd1;
                end
            end
        end
    end

    assign out_result = r_out_result;
    assign out_PC     = PC;
    assign halted_out = halted;

endmodule

// File: tb/tb_mips.sv
// Self-checking bench: directed and random programs, each compared against an
// instruction-at-a-time interpreter of the ISA.
module tb_mips;

    localparam logic [5:0] T_ADD = 6'b000000, T_SUB = 6'b000001, T_AND = 6'b000010,
                           T_OR = 6'b000011, T_SLT = 6'b000100, T_MUL = 6'b000101,
                           T_LW = 6'b001000, T_SW = 6'b001001, T_ADDI = 6'b001010,
                           T_SUBI = 6'b001011, T_SLTI = 6'b001100, T_BNEQZ = 6'b001101,
                           T_BEQZ = 6'b001110, T_HLT = 6'b111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] out_result, out_PC;
    logic        halted_out;

    mips #(.MEM_DEPTH(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .out_result (out_result),
        .out_PC     (out_PC),
        .halted_out (halted_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_taken = 0;
    int n_stall = 0;
    int taken0, stall0;

    always @(negedge clk) begin
        if (!rst) begin
            if (dut.taken_branch) n_taken++;
            if (dut.stall)        n_stall++;
        end
    end

    logic [31:0] img [1024];
    logic [31:0] init_regs [32];
    logic [31:0] m_mem [1024];
    logic [31:0] m_regs [32];
    logic [31:0] m_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic clear_image();
        for (int i = 0; i < 1024; i++) img[i] = 32'd0;
        for (int r = 0; r < 32; r++) init_regs[r] = 32'd0;
    endtask

    // Plain ISA interpreter: one instruction per step, no pipeline notion.
    task automatic model_run();
        logic [31:0] pc, ins, a, b, imm, addr;
        logic [5:0]  op;
        int          rs, rt, rd;
        for (int i = 0; i < 1024; i++) m_mem[i] = img[i];
        for (int r = 0; r < 32; r++) m_regs[r] = init_regs[r];
        m_regs[0] = 32'd0;
        m_last = 32'd0;
        pc = 32'd0;
        for (int step = 0; step < 2000; step++) begin
            ins = m_mem[pc % 1024];
            op  = ins[31:26];
            rs  = int'(ins[25:21]);
            rt  = int'(ins[20:16]);
            rd  = int'(ins[15:11]);
            imm = {{16{ins[15]}}, ins[15:0]};
            a   = m_regs[rs];
            b   = m_regs[rt];
            addr = a + imm;
            if (op == T_HLT) break;
            pc = pc + 1;
            case (op)
                T_ADD:  begin rd = rd; write_reg(rd, a + b); end
                T_SUB:  write_reg(rd, a - b);
                T_AND:  write_reg(rd, a & b);
                T_OR:   write_reg(rd, a | b);
                T_SLT:  write_reg(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                T_MUL:  write_reg(rd, a * b);
                T_LW:   write_reg(rt, m_mem[addr % 1024]);
                T_SW:   m_mem[addr % 1024] = b;
                T_ADDI: write_reg(rt, a + imm);
                T_SUBI: write_reg(rt, a - imm);
                T_SLTI: write_reg(rt, ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0);
                T_BEQZ:  if (a == 32'd0) pc = pc + imm;
                T_BNEQZ: if (a != 32'd0) pc = pc + imm;
                default: ;
            endcase
        end
    endtask

    task automatic write_reg(input int r, input logic [31:0] v);
        if (r != 0) begin
            m_regs[r] = v;
            m_last = v;
        end
    endtask

    task automatic load_prog();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) dut.Mem[i] = img[i];
        for (int r = 0; r < 32; r++) dut.regs[r] = init_regs[r];
        model_run();
        taken0 = n_taken;
        stall0 = n_stall;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic finish_prog(input string name);
        int cyc;
        cyc = 0;
        while (!halted_out && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " halted"}, {31'd0, halted_out}, 32'd1);
        for (int r = 0; r < 32; r++)
            check($sformatf("%s R%0d", name, r), dut.regs[r], m_regs[r]);
        for (int i = 200; i < 232; i++)
            check($sformatf("%s Mem[%0d]", name, i), dut.Mem[i], m_mem[i]);
        check({name, " out_result"}, out_result, m_last);
        $display("[TB] program %s done after %0d cycles, taken=%0d stall=%0d",
                 name, cyc, n_taken - taken0, n_stall - stall0);
    endtask

    task automatic build_chain(input logic [31:0] mem15);
        clear_image();
        init_regs[1] = 32'd10;
        img[15] = mem15;
        img[0] = enc_i(T_ADDI, 2, 1, 5);
        img[1] = enc_r(T_SUB, 3, 2, 1);
        img[2] = enc_i(T_LW, 4, 2, 0);
        img[3] = enc_r(T_ADD, 5, 4, 3);
        img[4] = enc_i(T_BEQZ, 0, 5, 2);
        img[5] = enc_i(T_ADDI, 6, 0, 99);
        img[6] = enc_i(T_ADDI, 6, 0, 42);
        img[7] = {T_HLT, 26'd0};
    endtask

    task automatic build_random(input int n);
        int k, rs, rt, rd;
        clear_image();
        for (int r = 1; r < 32; r++) init_regs[r] = $urandom();
        for (int i = 200; i < 232; i++) img[i] = $urandom();
        for (int i = 0; i < n; i++) begin
            k  = $urandom_range(0, 13);
            rs = $urandom_range(0, 15);
            rt = $urandom_range(0, 15);
            rd = $urandom_range(0, 15);
            case (k)
                0:  img[i] = enc_r(T_ADD, rd, rs, rt);
                1:  img[i] = enc_r(T_SUB, rd, rs, rt);
                2:  img[i] = enc_r(T_AND, rd, rs, rt);
                3:  img[i] = enc_r(T_OR,  rd, rs, rt);
                4:  img[i] = enc_r(T_SLT, rd, rs, rt);
                5:  img[i] = enc_r(T_MUL, rd, rs, rt);
                6:  img[i] = enc_i(T_ADDI, rt, rs, int'($urandom_range(0, 65535)));
                7:  img[i] = enc_i(T_SUBI, rt, rs, int'($urandom_range(0, 65535)));
                8:  img[i] = enc_i(T_SLTI, rt, rs, int'($urandom_range(0, 65535)));
                9, 10: img[i] = enc_i(T_LW, rt, 0, 200 + int'($urandom_range(0, 31)));
                11: img[i] = enc_i(T_SW, rt, 0, 200 + int'($urandom_range(0, 31)));
                12: img[i] = enc_i(T_BEQZ, 0, rs, int'($urandom_range(0, n - 1 - i)));
                default: img[i] = enc_i(T_BNEQZ, 0, rs, int'($urandom_range(0, n - 1 - i)));
            endcase
        end
        img[n] = {T_HLT, 26'd0};
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset out_PC", out_PC, 32'd0);
        check("reset halted", {31'd0, halted_out}, 32'd0);
        check("reset out_result", out_result, 32'd0);
        check("reset stall", {31'd0, dut.stall}, 32'd0);
        check("reset taken_branch", {31'd0, dut.taken_branch}, 32'd0);

        // Dependent chain, branch not taken
        build_chain(32'd7);
        load_prog();
        finish_prog("chain");
        check("chain R2", dut.regs[2], 32'd15);
        check("chain R3", dut.regs[3], 32'd5);
        check("chain R4", dut.regs[4], 32'd7);
        check("chain R5", dut.regs[5], 32'd12);
        check("chain R6", dut.regs[6], 32'd42);
        check("chain out_result", out_result, 32'd42);
        check("chain taken count", n_taken - taken0, 32'd0);

        // Same chain with R5=0: branch lands on HLT
        build_chain(32'hFFFF_FFFB);
        load_prog();
        finish_prog("chain_taken");
        check("taken R5", dut.regs[5], 32'd0);
        check("taken R6", dut.regs[6], 32'd0);
        check("taken count", n_taken - taken0, 32'd1);

        // Store, reload and use the loaded value
        clear_image();
        init_regs[1] = 32'd10;
        img[0] = enc_i(T_SW, 1, 0, 20);
        img[1] = enc_i(T_LW, 7, 0, 20);
        img[2] = enc_r(T_ADD, 12, 7, 1);
        img[3] = {T_HLT, 26'd0};
        load_prog();
        finish_prog("sw_lw");
        check("sw_lw R7", dut.regs[7], 32'd10);
        check("sw_lw Mem[20]", dut.Mem[20], 32'd10);
        check("sw_lw stall seen", {31'd0, (n_stall - stall0) > 0}, 32'd1);

        // Signed compare, multiply, and R0 discard
        clear_image();
        img[0] = enc_i(T_ADDI, 8, 0, -3);
        img[1] = enc_i(T_ADDI, 9, 0, 4);
        img[2] = enc_r(T_SLT, 10, 8, 9);
        img[3] = enc_r(T_MUL, 11, 8, 9);
        img[4] = enc_i(T_ADDI, 0, 0, 5);
        img[5] = {T_HLT, 26'd0};
        load_prog();
        finish_prog("slt_mul");
        check("slt R10", dut.regs[10], 32'd1);
        check("mul R11", dut.regs[11], 32'hFFFF_FFF4);
        check("R0 stays zero", dut.regs[0], 32'd0);

        // Reset in the middle of the chain program
        build_chain(32'd7);
        load_prog();
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst out_PC", out_PC, 32'd0);
        check("midrst halted", {31'd0, halted_out}, 32'd0);
        check("midrst out_result", out_result, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst no stale wb", out_result, 32'd0);
        finish_prog("midrst");
        check("midrst R6", dut.regs[6], 32'd42);

        // Random programs against the interpreter
        for (int t = 0; t < 8; t++) begin
            build_random(10 + int'($urandom_range(0, 14)));
            load_prog();
            finish_prog($sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
